cmd_serializer: RTL and testbench

SPI-master command serializer: accepts one parallel command {valid, opcode, key_addr, text_addr, dest_addr} over a valid/ready handshake and shifts it out MSB-first as a single chip-select frame (SPI mode 0). It is the transmit end of the control-group command link and drives the SPI receive port of the control unit's command deserializer. It is used by the host-side bridge and as the stimulus driver in system benches. Generated spi_clk is slow relative to clk so that the receiver's 2-flop synchronizer and edge detect see every edge.

---
 rtl/cmd_serializer.sv | 160 ++++++++++++++++
 tb/tb_cmd_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_serializer.sv
// SPI mode-0 master that shifts one parallel command out MSB-first in a single cs_n frame.
// Optional abort support is enabled by defining CMDSER_ABORT_EN (adds abort/aborted ports).
module cmd_serializer #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int CLKDIV  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_vbit,
  input  logic [OPCODEW-1:0] cmd_opcode,
  input  logic [ADDRW-1:0]   cmd_key_addr,
  input  logic [ADDRW-1:0]   cmd_text_addr,
  input  logic [ADDRW-1:0]   cmd_dest_addr,
`ifdef CMDSER_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               spi_clk,
  output logic               cs_n,
  output logic               mosi,
  output logic               busy,
  output logic               done
);

  localparam int FRAMEW = 1 + OPCODEW + 3 * ADDRW;
  localparam int BITW   = $clog2(FRAMEW + 1);
  localparam int DIVW   = 8;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(FRAMEW - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t              state_r, base_s, state_s;
  logic [DIVW-1:0]     div_r, div_s;
  logic [BITW-1:0]     bit_r, bit_s;
  logic [FRAMEW-1:0]   sreg_r, sreg_s;
  logic                abrt_r, abrt_s;
  logic                accept_s, div_end_s, abort_go_s, shift_s;
  logic                cs_n_r, spi_clk_r, mosi_r, busy_r, done_r, ready_r;
  logic                cs_n_s, spi_clk_s, mosi_s, done_s;

  assign accept_s  = cmd_valid && (state_r == S_IDLE);
  assign div_end_s = (div_r == DIV_LAST);
  assign shift_s   = (state_r == S_HIGH) && (state_s == S_LOW);

`ifdef CMDSER_ABORT_EN
  logic aborted_r, aborted_s;
  assign abort_go_s = abort && (state_r != S_IDLE);
  assign aborted_s  = (state_r == S_GAP) && (state_s == S_IDLE) && abrt_r;
  assign aborted    = aborted_r;
`else
  assign abort_go_s = 1'b0;
`endif

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      div_r     <= {DIVW{1'b0}};
      bit_r     <= {BITW{1'b0}};
      sreg_r    <= {FRAMEW{1'b0}};
      abrt_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      spi_clk_r <= 1'b0;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
`ifdef CMDSER_ABORT_EN
      aborted_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_r     <= bit_s;
      sreg_r    <= sreg_s;
      abrt_r    <= abrt_s;
      cs_n_r    <= cs_n_s;
      spi_clk_r <= spi_clk_s;
      mosi_r    <= mosi_s;
      busy_r    <= (state_s != S_IDLE);
      done_r    <= done_s;
      ready_r   <= (state_s == S_IDLE);
`ifdef CMDSER_ABORT_EN
      aborted_r <= aborted_s;
`endif
    end
  end

  // Next-state decode; abort overrides the normal sequence
  always_comb begin
    base_s = state_r;
    case (state_r)
      S_IDLE:  if (cmd_valid) base_s = S_SETUP; else base_s = S_IDLE;
      S_SETUP: if (div_end_s) base_s = S_HIGH;  else base_s = S_SETUP;
      S_HIGH: begin
        if (div_end_s) base_s = (bit_r == BIT_LAST) ? S_HOLD : S_LOW;
        else           base_s = S_HIGH;
      end
      S_LOW:   if (div_end_s) base_s = S_HIGH;  else base_s = S_LOW;
      S_HOLD:  if (div_end_s) base_s = S_GAP;   else base_s = S_HOLD;
      S_GAP:   if (div_end_s) base_s = S_IDLE;  else base_s = S_GAP;
      default: base_s = S_IDLE;
    endcase
    state_s = abort_go_s ? S_GAP : base_s;
  end

  // Datapath: divider, bit counter, frame shift register, abort flag
  always_comb begin
    div_s  = div_r;
    bit_s  = bit_r;
    sreg_s = sreg_r;
    abrt_s = abrt_r;
    if ((state_s != state_r) || abort_go_s || (state_s == S_IDLE)) div_s = {DIVW{1'b0}};
    else                                                            div_s = div_r + DIVW'(1);
    if (accept_s) begin
      bit_s  = {BITW{1'b0}};
      sreg_s = {cmd_vbit, cmd_opcode, cmd_key_addr, cmd_text_addr, cmd_dest_addr};
    end else if (shift_s) begin
      bit_s  = bit_r + BITW'(1);
      sreg_s = {sreg_r[FRAMEW-2:0], 1'b0};
    end else begin
      bit_s  = bit_r;
      sreg_s = sreg_r;
    end
    if (abort_go_s)              abrt_s = 1'b1;
    else if (state_s == S_IDLE)  abrt_s = 1'b0;
    else                         abrt_s = abrt_r;
  end

  // Output decode from the next state so every output is registered
  always_comb begin
    cs_n_s = 1'b1;
    case (state_s)
      S_SETUP, S_HIGH, S_LOW, S_HOLD: cs_n_s = 1'b0;
      default:                        cs_n_s = 1'b1;
    endcase
    spi_clk_s = (state_s == S_HIGH);
    mosi_s    = cs_n_s ? 1'b0 : sreg_s[FRAMEW-1];
    done_s    = (state_r == S_GAP) && (state_s == S_IDLE) && !abrt_r;
  end

  assign cs_n      = cs_n_r;
  assign spi_clk   = spi_clk_r;
  assign mosi      = mosi_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cmd_ready = ready_r;

endmodule

// File: tb/tb_cmd_serializer.sv
// Directed self-checking bench for cmd_serializer: frame content, timing, back-to-back, reset, abort.
module tb_cmd_serializer;

  localparam int ADDRW  = 24;
  localparam int OPW    = 2;
  localparam int CLKDIV = 4;
  localparam int FRAMEW = 1 + OPW + 3 * ADDRW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_vbit = 1'b0;
  logic [OPW-1:0]   cmd_opcode = '0;
  logic [ADDRW-1:0] cmd_key_addr = '0, cmd_text_addr = '0, cmd_dest_addr = '0;
  logic             spi_clk, cs_n, mosi, busy, done;
`ifdef CMDSER_ABORT_EN
  logic             abort = 1'b0;
  logic             aborted;
`endif

  cmd_serializer #(.ADDRW(ADDRW), .OPCODEW(OPW), .CLKDIV(CLKDIV)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vbit(cmd_vbit), .cmd_opcode(cmd_opcode), .cmd_key_addr(cmd_key_addr),
    .cmd_text_addr(cmd_text_addr), .cmd_dest_addr(cmd_dest_addr),
`ifdef CMDSER_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Hand-assembled frames {vbit, opcode, key, text, dest}
  localparam logic [FRAMEW-1:0] FR_A = 75'h6_ABCDEF_123456_00FF00; // 1,10,ABCDEF,123456,00FF00
  localparam logic [FRAMEW-1:0] FR_B = 75'h1_5A5A5A_C3C3C3_000001; // 0,01,5A5A5A,C3C3C3,000001
  localparam logic [FRAMEW-1:0] FR_C = 75'h5_000000_FFFFFF_800000; // 1,01,000000,FFFFFF,800000

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input logic [OPW-1:0] op,
                         input logic [ADDRW-1:0] k, input logic [ADDRW-1:0] t, input logic [ADDRW-1:0] d);
    cmd_vbit = v; cmd_opcode = op; cmd_key_addr = k; cmd_text_addr = t; cmd_dest_addr = d;
  endtask

  task automatic wait_done(input int bound, output int ok);
    ok = 0;
    for (int i = 0; i < bound && ok == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
  endtask

  task automatic wait_rises(input int n, input int bound, output int ok);
    logic prev;
    int   cnt;
    prev = spi_clk; cnt = 0; ok = 0;
    for (int i = 0; i < bound && ok == 0; i++) begin
      @(negedge clk);
      if (spi_clk === 1'b1 && prev === 1'b0) cnt++;
      prev = spi_clk;
      if (cnt == n) ok = 1;
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Frame monitor: samples at the falling clk edge, records each completed cs_n window
  logic [FRAMEW-1:0] cap = '0;
  logic [FRAMEW-1:0] fr_bits [8];
  int fr_rises [8], fr_cslow [8], fr_hib [8], fr_fall [8];
  int rises = 0, cs_low = 0, hi_run = 0, nframes = 0, edge_viol = 0, done_cnt = 0;
  initial begin
    logic prev_spi, prev_cs;
    prev_spi = 1'b0; prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (spi_clk === 1'b1 && prev_spi === 1'b0) begin
        if (cs_n !== 1'b0) edge_viol++;
        cap = {cap[FRAMEW-2:0], mosi};
        rises++;
      end
      if (done === 1'b1) done_cnt++;
      if (cs_n === 1'b0) begin
        if (prev_cs === 1'b1) begin
          fr_hib[nframes % 8]  = hi_run;
          fr_fall[nframes % 8] = cyc;
          hi_run = 0;
        end
        cs_low++;
      end else begin
        if (prev_cs === 1'b0) begin
          fr_bits[nframes % 8]  = cap;
          fr_rises[nframes % 8] = rises;
          fr_cslow[nframes % 8] = cs_low;
          nframes++;
          cap = '0; rises = 0; cs_low = 0;
        end
        hi_run++;
      end
      prev_spi = spi_clk;
      prev_cs  = cs_n;
    end
  end

  initial begin
    int ok, t_acc, t_d1, fa, fb;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: {cs_n, spi_clk, mosi, cmd_ready, done, busy}
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {cs_n, spi_clk, mosi, cmd_ready, done, busy}, 6'b100100);
    end

    // Single frame: content, edge count, cs_n width, accept-to-done latency
    set_cmd(1'b1, 2'b10, 24'hABCDEF, 24'h123456, 24'h00FF00);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t_acc = cyc;
    check("acc_cs_n", cs_n, 1'b0);
    check("acc_busy", busy, 1'b1);
    check("acc_ready", cmd_ready, 1'b0);
    check("acc_spi_low", spi_clk, 1'b0);
    check("acc_mosi_msb", mosi, 1'b1);
    wait_done(1000, ok);
    check("f1_done_seen", ok, 1);
    check("f1_latency", cyc - t_acc, 608);
    check("f1_ready_at_done", cmd_ready, 1'b1);
    fa = (nframes - 1) % 8;
    check("f1_bits", fr_bits[fa], FR_A);
    check("f1_rises", fr_rises[fa], FRAMEW);
    check("f1_cs_low", fr_cslow[fa], 604);
    repeat (5) @(negedge clk);

    // Back-to-back with mid-frame input toggles
    set_cmd(1'b1, 2'b10, 24'hABCDEF, 24'h123456, 24'h00FF00);
    cmd_valid = 1'b1;
    @(negedge clk);
    repeat (100) @(negedge clk);
    set_cmd(1'b1, 2'b11, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    repeat (200) @(negedge clk);
    set_cmd(1'b0, 2'b01, 24'h5A5A5A, 24'hC3C3C3, 24'h000001);
    wait_done(1000, ok);
    check("b2b_done1_seen", ok, 1);
    t_d1 = cyc;
    fa = (nframes - 1) % 8;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_cs_fall", cs_n, 1'b0);
    wait_done(1000, ok);
    check("b2b_done2_seen", ok, 1);
    fb = (nframes - 1) % 8;
    check("b2b_f1_bits", fr_bits[fa], FR_A);
    check("b2b_f2_bits", fr_bits[fb], FR_B);
    check("b2b_f2_rises", fr_rises[fb], FRAMEW);
    check("b2b_gap_min", fr_hib[fb] >= CLKDIV, 1'b1);
    check("b2b_fall_after_done", fr_fall[fb] - t_d1, 1);
    repeat (5) @(negedge clk);

    // Reset at rise 30, then a clean frame
    set_cmd(1'b1, 2'b01, 24'h000000, 24'hFFFFFF, 24'h800000);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rises(30, 2000, ok);
    check("rst_rise30_seen", ok, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {cs_n, spi_clk, mosi, cmd_ready, done, busy}, 6'b100100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(1000, ok);
    check("rst_frame_done", ok, 1);
    fa = (nframes - 1) % 8;
    check("rst_frame_bits", fr_bits[fa], FR_C);
    check("rst_frame_rises", fr_rises[fa], FRAMEW);
    repeat (5) @(negedge clk);

`ifdef CMDSER_ABORT_EN
    begin
      int d0, t_ab;
      d0 = done_cnt;
      set_cmd(1'b1, 2'b10, 24'hABCDEF, 24'h123456, 24'h00FF00);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_rises(10, 2000, ok);
      check("abt_rise10_seen", ok, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      t_ab = cyc;
      check("abt_outputs", {cs_n, spi_clk, mosi}, 3'b100);
      ok = 0;
      for (int i = 0; i < 50 && ok == 0; i++) begin
        @(negedge clk);
        if (aborted === 1'b1) ok = 1;
      end
      check("abt_pulse_seen", ok, 1);
      check("abt_pulse_delay", cyc - t_ab, CLKDIV);
      repeat (20) @(negedge clk);
      check("abt_no_done", done_cnt - d0, 0);
    end
`endif

    check("no_edge_while_deselected", edge_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
